reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - board-level reset sequencer with staged release and cause recording
//
// Holds the system in reset until the PLL has been locked for LOCK_CYCLES,
// then releases rst_core, and STAGE_CYCLES later releases rst_periph.
// PLL lock loss or a user request re-enters reset, and reset_cause records why.
//
// Optional feature macro: RESET_WATCHDOG_EN (watchdog counter active in RUN).
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high power-on reset
//   pll_locked   PLL lock, asynchronous to clk (synchronized internally)
//   user_req     debounced reset key, high = pressed (synchronized internally)
//   wdt_kick     watchdog service strobe (used only with RESET_WATCHDOG_EN)
//   rst_core     active-high reset for CPU/bus
//   rst_periph   active-high reset for peripherals
//   reset_cause  00 power-on, 01 PLL loss, 10 user, 11 watchdog
module reset_sequencer #(
  parameter int LOCK_CYCLES     = 32,
  parameter int STAGE_CYCLES    = 16,
  parameter int MIN_USER_CYCLES = 1024,
  parameter int WDT_CYCLES      = 1048576,
  parameter int CNT_W           = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       user_req,
  input  logic       wdt_kick,
  output logic       rst_core,
  output logic       rst_periph,
  output logic [1:0] reset_cause
);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_COUNT = 3'd1,
    S_STAGE = 3'd2,
    S_RUN   = 3'd3,
    S_USER  = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_PLL  = 2'b01;
  localparam logic [1:0] CAUSE_USER = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] USER_LAST  = CNT_W'(MIN_USER_CYCLES - 1);

  // Two-flop synchronizers for the asynchronous inputs.
  logic pll_meta_q, pll_s_q;
  logic user_meta_q, user_s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pll_meta_q  <= 1'b0;
      pll_s_q     <= 1'b0;
      user_meta_q <= 1'b0;
      user_s_q    <= 1'b0;
    end else begin
      pll_meta_q  <= pll_locked;
      pll_s_q     <= pll_meta_q;
      user_meta_q <= user_req;
      user_s_q    <= user_meta_q;
    end
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_q, core_d;
  logic             periph_q, periph_d;
  logic [1:0]       cause_q, cause_d;
  logic             wdt_expire;

`ifdef RESET_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

  logic [CNT_W-1:0] wdt_q, wdt_d;

  // Held at zero outside RUN, so it is already clear on RUN entry.
  // A kick on the terminal cycle suppresses expiry.
  always_comb begin
    wdt_d = wdt_q + 1'b1;
    if (state_q != S_RUN || wdt_kick) begin
      wdt_d = '0;
    end
  end

  assign wdt_expire = (state_q == S_RUN) && (wdt_q == WDT_LAST) && !wdt_kick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
  assign wdt_expire      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      core_q   <= 1'b1;
      periph_q <= 1'b1;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      core_q   <= core_d;
      periph_q <= periph_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    core_d   = core_q;
    periph_d = periph_q;
    cause_d  = cause_q;

    // Lock loss outranks everything except in HOLD, where we are already waiting.
    if (state_q != S_HOLD && !pll_s_q) begin
      state_d  = S_HOLD;
      cnt_d    = '0;
      core_d   = 1'b1;
      periph_d = 1'b1;
      cause_d  = CAUSE_PLL;
    end else begin
      case (state_q)
        S_HOLD: begin
          core_d   = 1'b1;
          periph_d = 1'b1;
          cnt_d    = '0;
          if (pll_s_q) begin
            state_d = S_COUNT;
          end
        end

        S_COUNT: begin
          if (cnt_q == LOCK_LAST) begin
            state_d = S_STAGE;
            cnt_d   = '0;
            core_d  = 1'b0;
          end
        end

        S_STAGE: begin
          if (user_s_q) begin
            state_d  = S_USER;
            cnt_d    = '0;
            core_d   = 1'b1;
            periph_d = 1'b1;
            cause_d  = CAUSE_USER;
          end else if (cnt_q == STAGE_LAST) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            periph_d = 1'b0;
          end
        end

        S_RUN: begin
          cnt_d = '0;
          if (wdt_expire) begin
            // PLL is still locked, so the lock wait is simply repeated.
            state_d  = S_COUNT;
            core_d   = 1'b1;
            periph_d = 1'b1;
            cause_d  = CAUSE_WDT;
          end else if (user_s_q) begin
            state_d  = S_USER;
            core_d   = 1'b1;
            periph_d = 1'b1;
            cause_d  = CAUSE_USER;
          end
        end

        S_USER: begin
          // Counter saturates so a held key keeps us here indefinitely.
          if (cnt_q == USER_LAST) begin
            cnt_d = cnt_q;
            if (!user_s_q) begin
              state_d = S_COUNT;
              cnt_d   = '0;
            end
          end
        end

        default: begin
          state_d  = S_HOLD;
          cnt_d    = '0;
          core_d   = 1'b1;
          periph_d = 1'b1;
        end
      endcase
    end
  end

  assign rst_core    = core_q;
  assign rst_periph  = periph_q;
  assign reset_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer output transitions
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       user_req;
  logic       wdt_kick;
  logic       rst_core;
  logic       rst_periph;
  logic [1:0] reset_cause;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    int         edge_no;
    logic [3:0] val;   // {rst_core, rst_periph, reset_cause}
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] prev;
  logic [3:0] cur;

  reset_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .user_req    (user_req),
    .wdt_kick    (wdt_kick),
    .rst_core    (rst_core),
    .rst_periph  (rst_periph),
    .reset_cause (reset_cause)
  );

  always #5 clk = ~clk;

  // Edge 1 is the first rising edge after reset falls.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, expv, edge_n);
    end
  endtask

  task automatic push(input int e, input logic c, input logic p, input logic [1:0] cause);
    exp_t x;
    x.edge_no = e;
    x.val     = {c, p, cause};
    exp_q.push_back(x);
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  // Every output change must match the next scoreboard entry in edge and value.
  always @(negedge clk) begin
    if (reset) begin
      prev = 4'b1100;
    end else begin
      cur = {rst_core, rst_periph, reset_cause};
      chk("periph_before_core", {31'd0, rst_core & ~rst_periph}, 32'd0);
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_change", {28'd0, cur}, {28'd0, prev});
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("change_edge", edge_n, e.edge_no);
          chk("change_value", {28'd0, cur}, {28'd0, e.val});
        end
        prev = cur;
      end
    end
  end

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b1;
    user_req   = 1'b0;
    wdt_kick   = 1'b0;

    // Power-on with PLL locked from the start.
    repeat (5) @(negedge clk);
    chk("reset_core",   {31'd0, rst_core},    32'd1);
    chk("reset_periph", {31'd0, rst_periph},  32'd1);
    chk("reset_cause",  {30'd0, reset_cause}, 32'd0);
    push(35, 1'b0, 1'b1, 2'b00);
    push(51, 1'b0, 1'b0, 2'b00);
    reset = 1'b0;

    // Kick in RUN has no effect without the watchdog feature.
    wait_edge(55); wdt_kick = 1'b1;
    wait_edge(56); wdt_kick = 1'b0;

    // Short user press (10 cycles) still gives the full minimum hold.
    wait_edge(60);
    push(63,   1'b1, 1'b1, 2'b10);
    push(1119, 1'b0, 1'b1, 2'b10);
    push(1135, 1'b0, 1'b0, 2'b10);
    user_req = 1'b1;
    wait_edge(70); user_req = 1'b0;

    // PLL loss and user press together in RUN: PLL loss wins.
    // Then a one-cycle glitch in COUNT restarts the full lock wait.
    wait_edge(1200);
    push(1203, 1'b1, 1'b1, 2'b01);
    push(1256, 1'b0, 1'b1, 2'b01);
    push(1272, 1'b0, 1'b0, 2'b01);
    pll_locked = 1'b0;
    user_req   = 1'b1;
    wait_edge(1210); pll_locked = 1'b1; user_req = 1'b0;
    wait_edge(1220); pll_locked = 1'b0;
    wait_edge(1221); pll_locked = 1'b1;

    // User key held 3000 cycles, then a PLL glitch during the lock count.
    wait_edge(1300);
    push(1303, 1'b1, 1'b1, 2'b10);
    push(4323, 1'b1, 1'b1, 2'b01);
    push(4356, 1'b0, 1'b1, 2'b01);
    push(4372, 1'b0, 1'b0, 2'b01);
    user_req = 1'b1;
    wait_edge(4300); user_req = 1'b0;
    wait_edge(4320); pll_locked = 1'b0;
    wait_edge(4321); pll_locked = 1'b1;

    // Asynchronous reset mid-run, then a late lock 100 cycles after release.
    wait_edge(4420);
    reset      = 1'b1;
    pll_locked = 1'b0;
    #1;
    chk("async_core",   {31'd0, rst_core},    32'd1);
    chk("async_periph", {31'd0, rst_periph},  32'd1);
    chk("async_cause",  {30'd0, reset_cause}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push(135, 1'b0, 1'b1, 2'b00);
    push(151, 1'b0, 1'b0, 2'b00);
    wait_edge(100); pll_locked = 1'b1;
    wait_edge(200);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
